multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_if.sv | 43 ++++
 rtl/multicycle_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller_if
//  Description : Control/status bundle between the multicycle MIPS controller
//                and its datapath.
//                master  - controller side (reads Op/Funct/Zero, drives
//                          control strobes, mux selects and debug State)
//                slave   - datapath side (the mirror image)
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_controller_if;
    // Instruction fields and ALU status from the datapath
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;

    // Control outputs
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic [3:0] State;

    modport master (
        input  Op, Funct, Zero,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, State
    );

    modport slave (
        output Op, Funct, Zero,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, State
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Moore FSM controller for a multicycle MIPS subset
//                (lw, sw, R-type, beq, addi, j) with ALU decoder.
//  Ports       : clk   - clock, all state changes on rising edge
//                reset - asynchronous active-high reset
//                bus   - multicycle_controller_if.master
//                        in : Op, Funct, Zero
//                        out: IorD, MemWrite, IRWrite, RegDst, MemtoReg,
//                             RegWrite, ALUSrcA, ALUSrcB, ALUControl,
//                             PCSrc, PCEn, State
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller (
    input  logic                           clk,
    input  logic                           reset,
    multicycle_controller_if.master        bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    state_t state_q, state_d;

    // Raw Moore-decoded controls (before reset gating)
    logic       iord, mem_write, ir_write, reg_dst, memto_reg, reg_write;
    logic       alu_src_a, pc_write, branch;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [2:0] alu_control;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Codes 12-15 fall into the default arm and recover
    // to FETCH on the next edge.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            // Op is held stable by the IR, so it still selects lw vs sw here
            MEMADR: state_d = (bus.Op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  state_d = MEMWB;
            EXEC:   state_d = ALUWB;
            ADDIEX: state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // ------------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------------
    always_comb begin
        iord      = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_dst   = 1'b0;
        memto_reg = 1'b0;
        reg_write = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        alu_op    = 2'b00;
        pc_src    = 2'b00;
        pc_write  = 1'b0;
        branch    = 1'b0;
        case (state_q)
            FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
            end
            DECODE: alu_src_b = 2'b11;
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD:  iord = 1'b1;
            MEMWB: begin
                memto_reg = 1'b1;
                reg_write = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDIWB: reg_write = 1'b1;
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // ALU decoder
    // ------------------------------------------------------------------------
    always_comb begin
        alu_control = 3'b010;
        case (alu_op)
            2'b01: alu_control = 3'b110;
            2'b10: begin
                case (bus.Funct)
                    6'b100010: alu_control = 3'b110;
                    6'b100100: alu_control = 3'b000;
                    6'b100101: alu_control = 3'b001;
                    6'b101010: alu_control = 3'b111;
                    default:   alu_control = 3'b010;
                endcase
            end
            default: alu_control = 3'b010;
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs. While reset is high the state is already FETCH, so the mux
    // selects show FETCH values; the write strobes are masked directly by
    // reset so nothing is written during the asynchronous reset window.
    // ------------------------------------------------------------------------
    assign bus.IorD       = iord;
    assign bus.MemWrite   = mem_write & ~reset;
    assign bus.IRWrite    = ir_write  & ~reset;
    assign bus.RegDst     = reg_dst;
    assign bus.MemtoReg   = memto_reg;
    assign bus.RegWrite   = reg_write & ~reset;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = alu_control;
    assign bus.PCSrc      = pc_src;
    assign bus.PCEn       = (pc_write | (branch & bus.Zero)) & ~reset;
    assign bus.State      = state_q;

endmodule
`default_nettype wire
